spi_read_scheduler: RTL and testbench
=====================================

// Module: spi_read_scheduler
// PURPOSE
//  Shares one simpleSPI read engine (rd / d_ready / d[15:0]) among NUM_REQ client requesters plus an internal
//  periodic refresh requester. Replaces ad-hoc SCLK-clocked refresh logic with a clk-domain scheduler:
//  arbitrates, issues rd, tracks d_ready, returns 16-bit data to the winner, enforces a timeout.
//  Sits between the sensor-read engine and the top-level consumers (LED display, sample logger).
// PARAMETERS
//  NUM_REQ        4        number of external requesters (1..8)
//  DATA_W         16       engine data width
//  REFRESH_CYCLES 200000   clk cycles between auto-refresh requests; 0 disables refresh
//  TIMEOUT_CYCLES 4096     max clk cycles in ISSUE+BUSY before abort
// PORTS
//  clk           in   1        system clock
//  rst_l         in   1        asynchronous reset, active low
//  req           in   NUM_REQ  level request per client; held until its ack pulse
//  ack           out  NUM_REQ  one-cycle pulse: client read complete, rdata/err valid this cycle
//  rdata         out  DATA_W   returned data, valid with ack
//  err           out  1        with ack: transaction timed out (rdata=0)
//  sample        out  DATA_W   last refresh result (held)
//  sample_valid  out  1        one-cycle pulse when sample updates
//  busy          out  1        high in ISSUE/BUSY/DONE
//  spi_rd        out  1        read start to engine
//  spi_d_ready   in   1        engine ready/done (1=idle/data valid, 0=busy); synchronous to clk
//  spi_d         in   DATA_W   engine read data
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0; refresh counter=0; refresh pending=0; timer=0.
//  Refresh: counter increments every clk; at REFRESH_CYCLES-1 wraps to 0, sets pending; tick while
//   pending already set coalesces (no double read). Pending clears when refresh slot is granted.
//  Arbitration: round-robin over {req[0..NUM_REQ-1], refresh} (refresh = slot NUM_REQ); search starts at
//   pointer; after grant pointer = winner+1 (mod NUM_REQ+1). Evaluated only in IDLE.
//  FSM:
//   IDLE  : any candidate -> latch winner, spi_rd<=1, timer<=0, ->ISSUE (spi_rd high cycle after req seen).
//   ISSUE : hold spi_rd=1 until spi_d_ready==0 sampled, then spi_rd<=0, ->BUSY.
//   BUSY  : wait spi_d_ready==1; capture spi_d, ->DONE.
//   DONE  : one cycle: client winner -> ack[w]=1, rdata=captured, err=0; refresh -> sample, sample_valid=1.
//           ->IDLE. Latency d_ready rise -> ack = 2 cycles.
//  Timeout: timer counts in ISSUE+BUSY; at TIMEOUT_CYCLES -> spi_rd<=0, ->DONE with err=1, rdata=0
//   (refresh timeout: sample unchanged, no sample_valid).
//  Requester drops req before DONE: transaction completes on engine, no ack, data discarded.
//  spi_d_ready already 0 when entering ISSUE: treated as accept on first ISSUE cycle.
//  Reset mid-operation: spi_rd drops asynchronously; no ack for in-flight read.
//  Never more than one ack bit high; ack never coincides with sample_valid.
//  Back-to-back: IDLE always spends >=1 cycle between transactions (engine recovery).
// STRUCTURE
//  spi_pkg: FSM state encodings (IDLE/ISSUE/BUSY/DONE), DATA_W default, timer width function.
//  Sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant + index; pure combinational + pointer reg.
//  Top holds FSM, refresh counter, timeout timer, capture registers.
// TESTING
//  1 single req[1]=1, engine model 40 clk busy returns 16'hA5C3 -> spi_rd 1 cyc after req, ack[1] with rdata=A5C3, err=0.
//  2 req=4'b1111 held -> grants 0,1,2,3,refresh(if pending),0.. in rotation; exactly one ack per transaction.
//  3 REFRESH_CYCLES=100, no req -> read every 100 cyc (subject to engine time), sample_valid pulses, sample=engine value.
//  4 engine never drops d_ready, TIMEOUT_CYCLES=64 -> ack with err=1, rdata=0 at 64 cycles; next req serviced normally.
//  5 req[2] dropped during BUSY -> no ack[2]; scheduler returns IDLE; next requester granted.
//  6 rst_l low mid-BUSY -> spi_rd=0, all outputs 0 immediately; after release first req served from pointer 0.

Source files
------------

// File: rtl/spi_read_scheduler_pkg.sv
// Shared types and helpers for the SPI read scheduler.
package spi_read_scheduler_pkg;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr; ptr moves past the winner on advance.
module rr_arbiter
  import spi_read_scheduler_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic [N-1:0] cand,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any
);
  localparam int IW = cnt_w(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW:0]   pos;
  logic [N-1:0]  rot;

  // Rotate so bit 0 is the candidate at ptr; first set bit wins.
  assign rot = N'({cand, cand} >> ptr);

  always_comb begin
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        pos = (IW+1)'(ptr) + (IW+1)'(i);
      end
    end
    idx   = (pos >= (IW+1)'(N)) ? IW'(pos - (IW+1)'(N)) : IW'(pos);
    grant = any ? (N'(1) << idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      ptr <= '0;
    else if (advance && any)
      ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/spi_read_scheduler.sv
// Shares one SPI read engine among NUM_REQ clients plus a periodic refresh reader,
// with round-robin arbitration and a transaction timeout.
module spi_read_scheduler
  import spi_read_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REFRESH_CYCLES = 200000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [DATA_W-1:0]  rdata,
  output logic               err,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               spi_rd,
  input  logic               spi_d_ready,
  input  logic [DATA_W-1:0]  spi_d
);
  localparam int N  = NUM_REQ + 1;
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int RW = cnt_w(REFRESH_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  state_t            state, nxt;
  logic [TW-1:0]     timer;
  logic [RW-1:0]     rcnt;
  logic              pend, tick;
  logic [N-1:0]      cand, grant, win;
  logic              any, adv, cap_en, abort, tmo, tout, recover, hit;
  logic [DATA_W-1:0] cap;

  assign cand = {pend, req};
  assign tick = (REFRESH_CYCLES != 0) && (rcnt == R_LAST);
  assign tmo  = (timer == T_LAST);
  assign busy = (state != ST_IDLE);
  // A client that dropped its request before completion gets no ack.
  assign hit  = |(win[NUM_REQ-1:0] & req);

  rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .rst_l  (rst_l),
    .cand   (cand),
    .advance(adv),
    .grant  (grant),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= nxt;
  end

  // recover holds off arbitration for one IDLE cycle after each transaction.
  always_comb begin
    nxt    = state;
    adv    = 1'b0;
    cap_en = 1'b0;
    abort  = 1'b0;
    case (state)
      ST_IDLE:
        if (any && !recover) begin
          adv = 1'b1;
          nxt = ST_ISSUE;
        end
      ST_ISSUE:
        if (tmo) begin
          abort = 1'b1;
          nxt   = ST_DONE;
        end else if (!spi_d_ready) begin
          nxt = ST_BUSY;
        end
      ST_BUSY:
        if (spi_d_ready) begin
          cap_en = 1'b1;
          nxt    = ST_DONE;
        end else if (tmo) begin
          abort = 1'b1;
          nxt   = ST_DONE;
        end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      spi_rd       <= 1'b0;
      recover      <= 1'b0;
      ack          <= '0;
      err          <= 1'b0;
      rdata        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      win          <= '0;
      timer        <= '0;
      tout         <= 1'b0;
      cap          <= '0;
    end else begin
      spi_rd       <= (nxt == ST_ISSUE);
      recover      <= (state == ST_DONE);
      ack          <= '0;
      err          <= 1'b0;
      rdata        <= '0;
      sample_valid <= 1'b0;
      if (adv) begin
        win   <= grant;
        timer <= '0;
        tout  <= 1'b0;
      end else if (state == ST_ISSUE || state == ST_BUSY) begin
        timer <= timer + 1'b1;
      end
      if (abort)  tout <= 1'b1;
      if (cap_en) cap  <= spi_d;
      if (state == ST_DONE) begin
        ack   <= win[NUM_REQ-1:0] & req;
        err   <= tout && hit;
        rdata <= (!tout && hit) ? cap : '0;
        if (win[NUM_REQ] && !tout) begin
          sample       <= cap;
          sample_valid <= 1'b1;
        end
      end
    end
  end

  // A tick while a refresh is already pending merges into it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rcnt <= '0;
      pend <= 1'b0;
    end else begin
      if (REFRESH_CYCLES != 0) rcnt <= tick ? '0 : rcnt + 1'b1;
      if (tick)                        pend <= 1'b1;
      else if (adv && grant[NUM_REQ]) pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_read_scheduler.sv
// Scoreboard bench: stimulus queues expected acks/samples, a forked monitor checks them.
module tb_spi_read_scheduler;
  localparam int NR = 4;
  localparam int DW = 16;

  typedef struct {
    bit          refr;
    int          id;
    logic [15:0] data;
    bit          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_l;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] ack;
  logic [DW-1:0] rdata, sample;
  logic [DW-1:0] spi_d = '0;
  logic          err, sample_valid, busy, spi_rd;
  logic          spi_d_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  exp_t sbq[$];

  int          eng_lat   = 5;
  logic [DW-1:0] eng_base = '0;
  bit          eng_stuck = 1'b0;
  int          eng_busy  = 0;
  int          eng_cnt   = 0;

  int cyc, n0, np, nrd;
  int tp[3];

  spi_read_scheduler #(
    .NUM_REQ(NR), .DATA_W(DW), .REFRESH_CYCLES(100), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_l(rst_l), .req(req), .ack(ack), .rdata(rdata), .err(err),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .spi_rd(spi_rd),
    .spi_d_ready(spi_d_ready), .spi_d(spi_d)
  );

  always #5 clk = ~clk;

  // Engine model: accepts rd while idle, busy eng_lat cycles, returns eng_base + read count.
  always @(negedge clk) begin
    if (!rst_l) begin
      spi_d_ready = 1'b1;
      eng_busy    = 0;
      eng_cnt     = 0;
    end else if (eng_busy > 0) begin
      eng_busy--;
      if (eng_busy == 0) begin
        spi_d       = eng_base + DW'(eng_cnt);
        eng_cnt++;
        spi_d_ready = 1'b1;
      end
    end else if (spi_rd && spi_d_ready && !eng_stuck) begin
      spi_d_ready = 1'b0;
      eng_busy    = eng_lat;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit r, input int id, input logic [15:0] d, input bit e);
    exp_t x;
    x.refr = r; x.id = id; x.data = d; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (|ack || sample_valid) begin
        chk("one_event", 32'($countones({ack, sample_valid})), 1);
        if (sbq.size() == 0) begin
          chk("unexpected_event", {27'b0, ack, sample_valid}, 0);
        end else begin
          e = sbq.pop_front();
          if (e.refr) begin
            chk("refresh_pulse", {27'b0, ack, sample_valid}, 1);
            chk("sample", 32'(sample), 32'(e.data));
          end else begin
            chk("ack_id", 32'(ack), 32'(1) << e.id);
            chk("rdata", 32'(rdata), 32'(e.data));
            chk("err", 32'(err), 32'(e.err));
          end
        end
      end
    end
  endtask

  task automatic wait_ack(input int id, input int maxc, output int c);
    c = 0;
    while (!ack[id] && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (!ack[id]) chk("wait_ack", 32'(ack[id]), 1);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic settle(input string nm);
    repeat (3) @(negedge clk);
    chk(nm, 32'(sbq.size()), 0);
  endtask

  task automatic wait_busy_phase();
    for (int c = 0; c < 60 && !(busy && !spi_rd); c++) @(negedge clk);
    chk("reach_busy", {30'b0, busy, spi_rd}, 32'b10);
  endtask

  initial begin
    rst_l = 1'b1;
    fork
      monitor();
    join_none
    #2 rst_l = 1'b0;
    @(negedge clk);
    chk("rst_spi_rd", 32'(spi_rd), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_sample_valid", 32'(sample_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: single client, 40-cycle engine
    eng_lat = 40; eng_base = 16'hA5C3;
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    push(1'b0, 1, 16'hA5C3, 1'b0);
    req[1] = 1'b1;
    chk("t1_rd_before", 32'(spi_rd), 0);
    @(negedge clk);
    chk("t1_rd_after", 32'(spi_rd), 1);
    wait_ack(1, 100, cyc);
    chk("t1_latency", 32'(cyc), 42);
    req[1] = 1'b0;
    settle("t1_sb_empty");

    // 2: all clients held, rotation 0,1,2,3,0
    eng_lat = 5; eng_base = 16'h2000;
    do_reset();
    push(1'b0, 0, 16'h2000, 1'b0);
    push(1'b0, 1, 16'h2001, 1'b0);
    push(1'b0, 2, 16'h2002, 1'b0);
    push(1'b0, 3, 16'h2003, 1'b0);
    push(1'b0, 0, 16'h2004, 1'b0);
    n0  = 0;
    req = 4'b1111;
    for (int c = 0; c < 200 && req != '0; c++) begin
      @(negedge clk);
      if (ack[0]) begin
        n0++;
        if (n0 == 2) req[0] = 1'b0;
      end
      req[NR-1:1] = req[NR-1:1] & ~ack[NR-1:1];
    end
    chk("t2_all_done", 32'(req), 0);
    settle("t2_sb_empty");

    // 3: periodic refresh, no clients
    eng_lat = 5; eng_base = 16'h3000;
    do_reset();
    push(1'b1, 0, 16'h3000, 1'b0);
    push(1'b1, 0, 16'h3001, 1'b0);
    push(1'b1, 0, 16'h3002, 1'b0);
    np = 0;
    for (int c = 0; c < 400 && np < 3; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        tp[np] = c;
        np++;
      end
    end
    chk("t3_pulses", 32'(np), 3);
    chk("t3_period1", 32'(tp[1] - tp[0]), 100);
    chk("t3_period2", 32'(tp[2] - tp[1]), 100);
    settle("t3_sb_empty");

    // 4: engine never accepts -> timeout, then normal service
    eng_lat = 5; eng_base = 16'h4000; eng_stuck = 1'b1;
    do_reset();
    push(1'b0, 0, 16'h0000, 1'b1);
    req[0] = 1'b1;
    nrd = 0;
    for (int c = 0; c < 200 && !ack[0]; c++) begin
      @(negedge clk);
      if (spi_rd) nrd++;
    end
    chk("t4_ack", 32'(ack[0]), 1);
    chk("t4_rd_cycles", 32'(nrd), 64);
    req[0] = 1'b0; eng_stuck = 1'b0;
    push(1'b0, 3, 16'h4000, 1'b0);
    req[3] = 1'b1;
    wait_ack(3, 100, cyc);
    req[3] = 1'b0;
    settle("t4_sb_empty");

    // 5: client 2 abandons during BUSY; client 3 served next
    eng_lat = 20; eng_base = 16'h5000;
    do_reset();
    push(1'b0, 3, 16'h5001, 1'b0);
    req = 4'b1100;
    wait_busy_phase();
    req[2] = 1'b0;
    wait_ack(3, 100, cyc);
    chk("t5_idle_at_ack", 32'(busy), 0);
    req[3] = 1'b0;
    settle("t5_sb_empty");

    // 6: reset during ISSUE and during BUSY
    eng_lat = 30; eng_base = 16'h6000; eng_stuck = 1'b1;
    do_reset();
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_rd_issue", 32'(spi_rd), 1);
    rst_l = 1'b0;
    #1;
    chk("t6_rd_async", 32'(spi_rd), 0);
    chk("t6_busy_async", 32'(busy), 0);
    repeat (2) @(negedge clk);
    eng_stuck = 1'b0;
    rst_l = 1'b1;
    wait_busy_phase();
    rst_l = 1'b0;
    #1;
    chk("t6_outs_async", {27'b0, ack, sample_valid}, 0);
    chk("t6_busy_rd", {29'b0, busy, spi_rd, err}, 0);
    chk("t6_rdata", 32'(rdata), 0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    push(1'b0, 0, 16'h6000, 1'b0);
    req = 4'b1111;
    wait_ack(0, 100, cyc);
    req = '0;
    settle("t6_sb_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
